ram_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer in front of the single-ported DPI-backed `RAMCtrl` memory model. It shares that port between the instruction fetch unit (read-only) and the load/store unit (read/write). It accepts one request at a time over valid/ready handshakes, drives the RAM port for exactly one cycle, and captures the one-cycle-registered read data. It then holds a response until the owning requester accepts it.

---
 rtl/ram_port_arbiter_if.sv | 54 +++++
 rtl/ram_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// Bundle of the requester handshakes and the RAMCtrl port seen by the
// IF/LS arbiter. The slave modport is the arbiter's view; the master modport
// is the view of the environment (requesters plus memory model).
interface ram_port_arbiter_if;

  // Instruction fetch request / response
  logic        if_req_valid;
  logic        if_req_ready;
  logic [63:0] if_req_addr;
  logic        if_rsp_valid;
  logic        if_rsp_ready;
  logic [63:0] if_rsp_data;

  // Load/store request / response
  logic        ls_req_valid;
  logic        ls_req_ready;
  logic [63:0] ls_req_addr;
  logic        ls_req_wen;
  logic [63:0] ls_req_wdata;
  logic [63:0] ls_req_wmask;
  logic        ls_rsp_valid;
  logic        ls_rsp_ready;
  logic [63:0] ls_rsp_data;

  // RAMCtrl read side (rdata is registered inside the RAM, one cycle late)
  logic [63:0] ram_raddr;
  logic        ram_rflag;
  logic [63:0] ram_rdata;

  // RAMCtrl write side
  logic [63:0] ram_waddr;
  logic [63:0] ram_wdata;
  logic [63:0] ram_wmask;
  logic        ram_wen;

  modport slave (
    input  if_req_valid, if_req_addr, if_rsp_ready,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    input  ls_req_valid, ls_req_addr, ls_req_wen, ls_req_wdata, ls_req_wmask, ls_rsp_ready,
    output ls_req_ready, ls_rsp_valid, ls_rsp_data,
    input  ram_rdata,
    output ram_raddr, ram_rflag, ram_waddr, ram_wdata, ram_wmask, ram_wen
  );

  modport master (
    output if_req_valid, if_req_addr, if_rsp_ready,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    output ls_req_valid, ls_req_addr, ls_req_wen, ls_req_wdata, ls_req_wmask, ls_rsp_ready,
    input  ls_req_ready, ls_rsp_valid, ls_rsp_data,
    output ram_rdata,
    input  ram_raddr, ram_rflag, ram_waddr, ram_wdata, ram_wmask, ram_wen
  );

endinterface

// File: rtl/ram_port_arbiter.sv
// Arbiter/sequencer sharing the single RAMCtrl port between the instruction
// fetch unit (read-only) and the load/store unit (read/write). One request is
// in flight at a time: IDLE grants, ISSUE drives the RAM for one cycle, WAIT
// captures the registered read data, RESP holds the response until the owner
// accepts it.
module ram_port_arbiter #(
  parameter int unsigned FIXED_PRIO = 0  // 0: round-robin, 1: LS wins ties
) (
  input  logic               clock,
  input  logic               reset,
  ram_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        prio_ls_q, prio_ls_d;    // 1: LS wins the next tie
  logic        owner_ls_q, owner_ls_d;  // 1: request in flight belongs to LS
  logic        wen_q, wen_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] wmask_q, wmask_d;
  logic [63:0] rdata_q, rdata_d;

  logic        ls_wins_tie_s;
  logic        grant_if_s;
  logic        grant_ls_s;
  logic        rsp_ready_s;
  logic        in_issue_s;

  // Combinational grant: only in IDLE and outside reset, at most one winner
  always_comb begin
    ls_wins_tie_s = (FIXED_PRIO != 32'd0) || prio_ls_q;
    grant_if_s    = 1'b0;
    grant_ls_s    = 1'b0;
    if ((state_q == S_IDLE) && !reset) begin
      if (bus.ls_req_valid && (!bus.if_req_valid || ls_wins_tie_s)) begin
        grant_ls_s = 1'b1;
      end else if (bus.if_req_valid) begin
        grant_if_s = 1'b1;
      end else begin
        grant_if_s = 1'b0;
        grant_ls_s = 1'b0;
      end
    end else begin
      grant_if_s = 1'b0;
      grant_ls_s = 1'b0;
    end
  end

  // Ready of the requester that owns the held response
  always_comb begin
    if (owner_ls_q) begin
      rsp_ready_s = bus.ls_rsp_ready;
    end else begin
      rsp_ready_s = bus.if_rsp_ready;
    end
  end

  // Next-state and datapath-load logic for the request sequencer
  always_comb begin
    state_d    = state_q;
    prio_ls_d  = prio_ls_q;
    owner_ls_d = owner_ls_q;
    wen_d      = wen_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    rdata_d    = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (grant_ls_s) begin
          state_d    = S_ISSUE;
          owner_ls_d = 1'b1;
          prio_ls_d  = 1'b0;  // IF gets the next tie
          addr_d     = bus.ls_req_addr;
          wen_d      = bus.ls_req_wen;
          wdata_d    = bus.ls_req_wdata;
          wmask_d    = bus.ls_req_wmask;
        end else if (grant_if_s) begin
          state_d    = S_ISSUE;
          owner_ls_d = 1'b0;
          prio_ls_d  = 1'b1;  // LS gets the next tie
          addr_d     = bus.if_req_addr;
          wen_d      = 1'b0;  // IF never writes
          wdata_d    = 64'd0;
          wmask_d    = 64'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // RAM read data is valid now; writes are acknowledged with zero
        if (wen_q) begin
          rdata_d = 64'd0;
        end else begin
          rdata_d = bus.ram_rdata;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      prio_ls_q  <= 1'b0;
      owner_ls_q <= 1'b0;
      wen_q      <= 1'b0;
      addr_q     <= 64'd0;
      wdata_q    <= 64'd0;
      wmask_q    <= 64'd0;
      rdata_q    <= 64'd0;
    end else begin
      state_q    <= state_d;
      prio_ls_q  <= prio_ls_d;
      owner_ls_q <= owner_ls_d;
      wen_q      <= wen_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      rdata_q    <= rdata_d;
    end
  end

  // RAM strobes are one-cycle pulses in ISSUE, forced low while in reset
  assign in_issue_s = (state_q == S_ISSUE) && !reset;

  assign bus.if_req_ready = grant_if_s;
  assign bus.ls_req_ready = grant_ls_s;

  assign bus.if_rsp_valid = (state_q == S_RESP) && !owner_ls_q && !reset;
  assign bus.ls_rsp_valid = (state_q == S_RESP) &&  owner_ls_q && !reset;
  assign bus.if_rsp_data  = rdata_q;
  assign bus.ls_rsp_data  = rdata_q;

  assign bus.ram_rflag = in_issue_s && !wen_q;
  assign bus.ram_wen   = in_issue_s &&  wen_q;
  assign bus.ram_raddr = addr_q;
  assign bus.ram_waddr = addr_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.ram_wmask = wmask_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: a round-robin instance backed by a
// small RAMCtrl model, plus a fixed-priority instance for the tie test.
module tb_ram_port_arbiter;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  ram_port_arbiter_if ifc0 ();
  ram_port_arbiter_if ifc1 ();

  ram_port_arbiter #(.FIXED_PRIO(0)) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (ifc0.slave)
  );

  ram_port_arbiter #(.FIXED_PRIO(1)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (ifc1.slave)
  );

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] IF_ADDR  = 64'h0000_0000_8000_0000;
  localparam logic [63:0] IF_DATA  = 64'h0000_0013_0000_0093;
  localparam logic [63:0] LS_ADDR  = 64'h0000_0000_8000_1000;
  localparam logic [63:0] LS_INIT  = 64'h1111_2222_3333_4444;
  localparam logic [63:0] LS_WDATA = 64'h0000_0000_DEAD_BEEF;
  localparam logic [63:0] LS_WMASK = 64'h0000_0000_FFFF_FFFF;
  localparam logic [63:0] LS_AFTER = 64'h1111_2222_DEAD_BEEF;

  // RAMCtrl model for dut0: registered read data, masked write
  logic [63:0] mem [logic [63:0]];
  int rflag_pulses = 0;
  int wen_pulses   = 0;
  int overlap      = 0;

  always @(posedge clock) begin
    if (ifc0.ram_rflag) begin
      rflag_pulses++;
      ifc0.ram_rdata <= mem.exists(ifc0.ram_raddr) ? mem[ifc0.ram_raddr] : 64'd0;
    end
    if (ifc0.ram_wen) begin
      wen_pulses++;
      if (!mem.exists(ifc0.ram_waddr)) mem[ifc0.ram_waddr] = 64'd0;
      mem[ifc0.ram_waddr] = (mem[ifc0.ram_waddr] & ~ifc0.ram_wmask) | (ifc0.ram_wdata & ifc0.ram_wmask);
    end
  end

  // Watch for strobes or responses that must never coincide
  always @(negedge clock) begin
    if (ifc0.ram_rflag && ifc0.ram_wen) overlap++;
    if (ifc0.if_rsp_valid && ifc0.ls_rsp_valid) overlap++;
  end

  task automatic idle_inputs();
    ifc0.if_req_valid = 1'b0; ifc0.if_req_addr = 64'd0; ifc0.if_rsp_ready = 1'b0;
    ifc0.ls_req_valid = 1'b0; ifc0.ls_req_addr = 64'd0; ifc0.ls_req_wen = 1'b0;
    ifc0.ls_req_wdata = 64'd0; ifc0.ls_req_wmask = 64'd0; ifc0.ls_rsp_ready = 1'b0;
    ifc1.if_req_valid = 1'b0; ifc1.if_req_addr = 64'd0; ifc1.if_rsp_ready = 1'b0;
    ifc1.ls_req_valid = 1'b0; ifc1.ls_req_addr = 64'd0; ifc1.ls_req_wen = 1'b0;
    ifc1.ls_req_wdata = 64'd0; ifc1.ls_req_wmask = 64'd0; ifc1.ls_rsp_ready = 1'b0;
    ifc1.ram_rdata = 64'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    ifc0.if_req_valid = 1'b1;
    ifc0.ls_req_valid = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (ifc0.if_req_ready !== 1'b0) begin errors++; $display("FAIL reset_if_ready: got %b want 0", ifc0.if_req_ready); end
    checks++; if (ifc0.ls_req_ready !== 1'b0) begin errors++; $display("FAIL reset_ls_ready: got %b want 0", ifc0.ls_req_ready); end
    checks++; if (ifc0.ram_rflag !== 1'b0) begin errors++; $display("FAIL reset_rflag: got %b want 0", ifc0.ram_rflag); end
    checks++; if (ifc0.ram_wen !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b want 0", ifc0.ram_wen); end
    checks++; if (ifc0.if_rsp_valid !== 1'b0 || ifc0.ls_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b%b want 00", ifc0.if_rsp_valid, ifc0.ls_rsp_valid); end
    checks++; if (ifc0.ram_raddr !== 64'd0 || ifc0.if_rsp_data !== 64'd0) begin errors++; $display("FAIL reset_addr_data: got %h/%h want 0/0", ifc0.ram_raddr, ifc0.if_rsp_data); end
    ifc0.if_req_valid = 1'b0;
    ifc0.ls_req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    checks++; if (ifc0.if_req_ready !== 1'b0 || ifc0.ram_rflag !== 1'b0) begin errors++; $display("FAIL post_reset_quiet: got ready=%b rflag=%b want 0/0", ifc0.if_req_ready, ifc0.ram_rflag); end
  endtask

  task automatic test_if_read();
    int start_pulses;
    mem[IF_ADDR] = IF_DATA;
    start_pulses = rflag_pulses;
    ifc0.if_req_addr  = IF_ADDR;
    ifc0.if_req_valid = 1'b1;
    #1;
    checks++; if (ifc0.if_req_ready !== 1'b1 || ifc0.ls_req_ready !== 1'b0) begin errors++; $display("FAIL ifrd_grant: got if=%b ls=%b want 1/0", ifc0.if_req_ready, ifc0.ls_req_ready); end
    @(negedge clock);  // ISSUE
    ifc0.if_req_valid = 1'b0;
    checks++; if (ifc0.ram_rflag !== 1'b1 || ifc0.ram_wen !== 1'b0) begin errors++; $display("FAIL ifrd_issue_strobes: got rflag=%b wen=%b want 1/0", ifc0.ram_rflag, ifc0.ram_wen); end
    checks++; if (ifc0.ram_raddr !== IF_ADDR) begin errors++; $display("FAIL ifrd_raddr: got %h want %h", ifc0.ram_raddr, IF_ADDR); end
    checks++; if (ifc0.if_rsp_valid !== 1'b0) begin errors++; $display("FAIL ifrd_early_rsp_issue: got %b want 0", ifc0.if_rsp_valid); end
    @(negedge clock);  // WAIT
    checks++; if (ifc0.ram_rflag !== 1'b0 || ifc0.if_rsp_valid !== 1'b0) begin errors++; $display("FAIL ifrd_wait: got rflag=%b rsp=%b want 0/0", ifc0.ram_rflag, ifc0.if_rsp_valid); end
    @(negedge clock);  // RESP
    checks++; if (ifc0.if_rsp_valid !== 1'b1 || ifc0.ls_rsp_valid !== 1'b0) begin errors++; $display("FAIL ifrd_rsp_valid: got if=%b ls=%b want 1/0", ifc0.if_rsp_valid, ifc0.ls_rsp_valid); end
    checks++; if (ifc0.if_rsp_data !== IF_DATA) begin errors++; $display("FAIL ifrd_rsp_data: got %h want %h", ifc0.if_rsp_data, IF_DATA); end
    checks++; if (rflag_pulses - start_pulses !== 1) begin errors++; $display("FAIL ifrd_rflag_pulses: got %0d want 1", rflag_pulses - start_pulses); end
    ifc0.if_rsp_ready = 1'b1;
    @(negedge clock);
    ifc0.if_rsp_ready = 1'b0;
    checks++; if (ifc0.if_rsp_valid !== 1'b0) begin errors++; $display("FAIL ifrd_rsp_drop: got %b want 0", ifc0.if_rsp_valid); end
  endtask

  task automatic test_ls_write_read();
    int start_wen;
    mem[LS_ADDR] = LS_INIT;
    start_wen = wen_pulses;
    ifc0.ls_req_addr  = LS_ADDR;
    ifc0.ls_req_wen   = 1'b1;
    ifc0.ls_req_wdata = LS_WDATA;
    ifc0.ls_req_wmask = LS_WMASK;
    ifc0.ls_req_valid = 1'b1;
    #1;
    checks++; if (ifc0.ls_req_ready !== 1'b1 || ifc0.if_req_ready !== 1'b0) begin errors++; $display("FAIL lswr_grant: got ls=%b if=%b want 1/0", ifc0.ls_req_ready, ifc0.if_req_ready); end
    @(negedge clock);  // ISSUE
    ifc0.ls_req_valid = 1'b0;
    checks++; if (ifc0.ram_wen !== 1'b1 || ifc0.ram_rflag !== 1'b0) begin errors++; $display("FAIL lswr_strobes: got wen=%b rflag=%b want 1/0", ifc0.ram_wen, ifc0.ram_rflag); end
    checks++; if (ifc0.ram_waddr !== LS_ADDR || ifc0.ram_wdata !== LS_WDATA || ifc0.ram_wmask !== LS_WMASK) begin errors++; $display("FAIL lswr_bus: got %h %h %h want %h %h %h", ifc0.ram_waddr, ifc0.ram_wdata, ifc0.ram_wmask, LS_ADDR, LS_WDATA, LS_WMASK); end
    @(negedge clock);  // WAIT
    checks++; if (ifc0.ram_wen !== 1'b0) begin errors++; $display("FAIL lswr_wen_drop: got %b want 0", ifc0.ram_wen); end
    @(negedge clock);  // RESP
    checks++; if (ifc0.ls_rsp_valid !== 1'b1 || ifc0.ls_rsp_data !== 64'd0) begin errors++; $display("FAIL lswr_ack: got valid=%b data=%h want 1/0", ifc0.ls_rsp_valid, ifc0.ls_rsp_data); end
    checks++; if (wen_pulses - start_wen !== 1) begin errors++; $display("FAIL lswr_wen_pulses: got %0d want 1", wen_pulses - start_wen); end
    ifc0.ls_rsp_ready = 1'b1;
    @(negedge clock);
    ifc0.ls_rsp_ready = 1'b0;
    ifc0.ls_req_wen   = 1'b0;
    ifc0.ls_req_valid = 1'b1;
    #1;
    checks++; if (ifc0.ls_req_ready !== 1'b1) begin errors++; $display("FAIL lsrd_grant: got %b want 1", ifc0.ls_req_ready); end
    @(negedge clock);
    ifc0.ls_req_valid = 1'b0;
    checks++; if (ifc0.ram_rflag !== 1'b1 || ifc0.ram_wen !== 1'b0) begin errors++; $display("FAIL lsrd_strobes: got rflag=%b wen=%b want 1/0", ifc0.ram_rflag, ifc0.ram_wen); end
    repeat (2) @(negedge clock);
    checks++; if (ifc0.ls_rsp_valid !== 1'b1 || ifc0.ls_rsp_data !== LS_AFTER) begin errors++; $display("FAIL lsrd_data: got valid=%b data=%h want 1/%h", ifc0.ls_rsp_valid, ifc0.ls_rsp_data, LS_AFTER); end
    ifc0.ls_rsp_ready = 1'b1;
    @(negedge clock);
    ifc0.ls_rsp_ready = 1'b0;
  endtask

  task automatic test_arbitration();
    logic exp_if;
    exp_if = 1'b1;  // pointer rests on IF after the previous LS-only grants
    ifc0.if_req_addr = IF_ADDR; ifc0.ls_req_addr = LS_ADDR; ifc0.ls_req_wen = 1'b0;
    ifc1.if_req_addr = IF_ADDR; ifc1.ls_req_addr = LS_ADDR; ifc1.ls_req_wen = 1'b0;
    ifc0.if_rsp_ready = 1'b1; ifc0.ls_rsp_ready = 1'b1;
    ifc1.if_rsp_ready = 1'b1; ifc1.ls_rsp_ready = 1'b1;
    ifc0.if_req_valid = 1'b1; ifc0.ls_req_valid = 1'b1;
    ifc1.if_req_valid = 1'b1; ifc1.ls_req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if (ifc0.if_req_ready !== exp_if || ifc0.ls_req_ready !== !exp_if) begin errors++; $display("FAIL rr_grant_%0d: got if=%b ls=%b want %b/%b", i, ifc0.if_req_ready, ifc0.ls_req_ready, exp_if, !exp_if); end
      checks++; if (ifc1.ls_req_ready !== 1'b1 || ifc1.if_req_ready !== 1'b0) begin errors++; $display("FAIL fixed_grant_%0d: got if=%b ls=%b want 0/1", i, ifc1.if_req_ready, ifc1.ls_req_ready); end
      exp_if = !exp_if;
      repeat (4) @(negedge clock);
    end
    idle_inputs();
    @(negedge clock);
  endtask

  task automatic test_backpressure();
    ifc0.ls_req_addr  = LS_ADDR;
    ifc0.ls_req_wen   = 1'b0;
    ifc0.ls_req_valid = 1'b1;
    #1;
    checks++; if (ifc0.ls_req_ready !== 1'b1) begin errors++; $display("FAIL bp_ls_grant: got %b want 1", ifc0.ls_req_ready); end
    @(negedge clock);  // ISSUE
    ifc0.ls_req_valid = 1'b0;
    ifc0.if_req_addr  = IF_ADDR;
    ifc0.if_req_valid = 1'b1;
    #1;
    checks++; if (ifc0.if_req_ready !== 1'b0) begin errors++; $display("FAIL bp_if_ready_issue: got %b want 0", ifc0.if_req_ready); end
    repeat (2) @(negedge clock);  // RESP
    checks++; if (ifc0.ls_rsp_valid !== 1'b1 || ifc0.ls_rsp_data !== LS_AFTER) begin errors++; $display("FAIL bp_rsp_first: got valid=%b data=%h want 1/%h", ifc0.ls_rsp_valid, ifc0.ls_rsp_data, LS_AFTER); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++; if (ifc0.ls_rsp_valid !== 1'b1 || ifc0.ls_rsp_data !== LS_AFTER || ifc0.if_req_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_%0d: got valid=%b data=%h if_ready=%b want 1/%h/0", i, ifc0.ls_rsp_valid, ifc0.ls_rsp_data, ifc0.if_req_ready, LS_AFTER); end
    end
    ifc0.ls_rsp_ready = 1'b1;
    @(negedge clock);  // handshake done, back in IDLE
    ifc0.ls_rsp_ready = 1'b0;
    #1;
    checks++; if (ifc0.ls_rsp_valid !== 1'b0 || ifc0.if_req_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got ls_valid=%b if_ready=%b want 0/1", ifc0.ls_rsp_valid, ifc0.if_req_ready); end
    @(negedge clock);
    ifc0.if_req_valid = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (ifc0.if_rsp_valid !== 1'b1 || ifc0.if_rsp_data !== IF_DATA) begin errors++; $display("FAIL bp_if_done: got valid=%b data=%h want 1/%h", ifc0.if_rsp_valid, ifc0.if_rsp_data, IF_DATA); end
    ifc0.if_rsp_ready = 1'b1;
    @(negedge clock);
    ifc0.if_rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    ifc0.if_req_addr  = IF_ADDR;
    ifc0.if_req_valid = 1'b1;
    @(negedge clock);  // ISSUE
    ifc0.if_req_valid = 1'b0;
    @(negedge clock);  // WAIT
    reset = 1'b1;
    #1;
    checks++; if (ifc0.ram_rflag !== 1'b0 || ifc0.ram_wen !== 1'b0 || ifc0.if_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_wait_gated: got rflag=%b wen=%b rsp=%b want 000", ifc0.ram_rflag, ifc0.ram_wen, ifc0.if_rsp_valid); end
    @(negedge clock);
    checks++; if (ifc0.ram_raddr !== 64'd0 || ifc0.ram_waddr !== 64'd0 || ifc0.ram_wdata !== 64'd0 || ifc0.ram_wmask !== 64'd0) begin errors++; $display("FAIL rst_ram_bus: got %h %h %h %h want 0", ifc0.ram_raddr, ifc0.ram_waddr, ifc0.ram_wdata, ifc0.ram_wmask); end
    checks++; if (ifc0.if_rsp_data !== 64'd0 || ifc0.ls_rsp_data !== 64'd0 || ifc0.if_rsp_valid !== 1'b0 || ifc0.ls_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp: got %h %h %b %b want 0", ifc0.if_rsp_data, ifc0.ls_rsp_data, ifc0.if_rsp_valid, ifc0.ls_rsp_valid); end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++; if (ifc0.if_rsp_valid !== 1'b0 || ifc0.ram_rflag !== 1'b0) begin errors++; $display("FAIL rst_no_ghost_%0d: got rsp=%b rflag=%b want 0/0", i, ifc0.if_rsp_valid, ifc0.ram_rflag); end
    end
    ifc0.if_req_valid = 1'b1;
    #1;
    checks++; if (ifc0.if_req_ready !== 1'b1) begin errors++; $display("FAIL rst_new_grant: got %b want 1", ifc0.if_req_ready); end
    @(negedge clock);
    ifc0.if_req_valid = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (ifc0.if_rsp_valid !== 1'b1 || ifc0.if_rsp_data !== IF_DATA) begin errors++; $display("FAIL rst_new_read: got valid=%b data=%h want 1/%h", ifc0.if_rsp_valid, ifc0.if_rsp_data, IF_DATA); end
    ifc0.if_rsp_ready = 1'b1;
    @(negedge clock);
    ifc0.if_rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_ls_write_read();
    test_arbitration();
    test_backpressure();
    test_reset_mid();
    checks++; if (overlap !== 0) begin errors++; $display("FAIL strobe_overlap: got %0d want 0", overlap); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
